// File: rtl/resp_reorder_buf.sv
// Response reorder buffer: stores tagged response beats in a row x column
// grid and releases each row's beats strictly in column order. A round-robin
// arbiter chooses among rows, and the original ID is restored per row.
module resp_reorder_buf #(
  parameter int ID_WIDTH        = 4,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4,
  localparam int IDX_W          = $clog2(MAX_OUTSTANDING),
  localparam int OCC_W          = $clog2(MAX_OUTSTANDING*MAX_OUTSTANDING+1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  bind_valid,
  input  logic [IDX_W-1:0]      bind_row,
  input  logic [ID_WIDTH-1:0]   bind_id,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2*IDX_W-1:0]    in_uid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [1:0]            in_resp,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ID_WIDTH-1:0]   out_id,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [1:0]            out_resp,
  output logic [OCC_W-1:0]      occupancy
);

  localparam int N = MAX_OUTSTANDING;

  logic                  ent_valid [N][N];
  logic [DATA_WIDTH-1:0] ent_data  [N][N];
  logic [1:0]            ent_resp  [N][N];
  logic [ID_WIDTH-1:0]   row_id    [N];
  logic [IDX_W-1:0]      exp_col   [N];
  logic [IDX_W-1:0]      rr_ptr;

  logic [IDX_W-1:0]      in_row;
  logic [IDX_W-1:0]      in_col;
  logic [N-1:0]          eligible;
  logic                  grant_found;
  logic [IDX_W-1:0]      grant_row;
  logic [IDX_W-1:0]      search_row;
  logic                  wr_en;
  logic                  load_en;

  assign in_row   = in_uid[2*IDX_W-1:IDX_W];
  assign in_col   = in_uid[IDX_W-1:0];
  assign in_ready = !ent_valid[in_row][in_col];
  assign wr_en    = in_valid && in_ready;
  assign load_en  = grant_found && (!out_valid || out_ready);

  // A row may be drained only when its next expected column is present.
  always_comb begin
    eligible = '0;
    for (int r = 0; r < N; r++) begin
      eligible[r] = ent_valid[r][exp_col[r]];
    end
  end

  // Round-robin search beginning one past the last granted row.
  always_comb begin
    grant_found = 1'b0;
    grant_row   = '0;
    search_row  = '0;
    for (int k = 1; k <= N; k++) begin
      search_row = rr_ptr + IDX_W'(k);
      if (!grant_found && eligible[search_row]) begin
        grant_found = 1'b1;
        grant_row   = search_row;
      end
    end
  end

  // Entry storage: set on accepted write, cleared when moved to the output.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          ent_valid[r][c] <= 1'b0;
          ent_data[r][c]  <= '0;
          ent_resp[r][c]  <= '0;
        end
      end
    end else begin
      if (load_en) begin
        ent_valid[grant_row][exp_col[grant_row]] <= 1'b0;
      end
      if (wr_en) begin
        ent_valid[in_row][in_col] <= 1'b1;
        ent_data[in_row][in_col]  <= in_data;
        ent_resp[in_row][in_col]  <= in_resp;
      end
    end
  end

  // Per-row bookkeeping: ID binding, expected column and arbiter pointer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < N; r++) begin
        row_id[r]  <= '0;
        exp_col[r] <= '0;
      end
      rr_ptr <= '0;
    end else begin
      if (bind_valid) begin
        row_id[bind_row] <= bind_id;
      end
      if (load_en) begin
        exp_col[grant_row] <= exp_col[grant_row] + 1'b1;
        rr_ptr             <= grant_row;
      end
    end
  end

  // Output register: loads from the granted row, holds under backpressure.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_id    <= '0;
      out_data  <= '0;
      out_resp  <= '0;
    end else if (load_en) begin
      out_valid <= 1'b1;
      out_id    <= row_id[grant_row];
      out_data  <= ent_data[grant_row][exp_col[grant_row]];
      out_resp  <= ent_resp[grant_row][exp_col[grant_row]];
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Stored-entry count; a write and a load in the same cycle cancel out.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occupancy <= '0;
    end else begin
      case ({wr_en, load_en})
        2'b10:   occupancy <= occupancy + 1'b1;
        2'b01:   occupancy <= occupancy - 1'b1;
        default: occupancy <= occupancy;
      endcase
    end
  end

endmodule
